// File: rtl/vx_icache_responder_pkg.sv
// Shared definitions for the instruction-cache responder: tag width default,
// word-address width and the address range helper.
package vx_icache_responder_pkg;

  localparam int NW_BITS     = 4;
  localparam int WORD_ADDR_W = 30;
  localparam int INSTR_W     = 32;

  // True when a word address falls inside a memory of 'words' entries.
  function automatic logic addr_in_range(input logic [WORD_ADDR_W-1:0] addr,
                                         input int unsigned words);
    return ({2'b00, addr} < words);
  endfunction

endpackage

// File: rtl/vx_icache_rsp_fifo.sv
// First-word fall-through response FIFO. The head entry is presented
// combinationally whenever the FIFO holds data; pops are ignored when empty.
module vx_icache_rsp_fifo #(
  parameter int DATAW = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATAW-1:0] store [DEPTH];
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign out_valid = (wptr != rptr);
  assign out_data  = store[rptr[PTR_W-1:0]];
  assign do_pop    = pop && out_valid;

  // Entry storage; contents need no reset since validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (push) store[wptr[PTR_W-1:0]] <= push_data;
  end

  // Read and write pointer advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/vx_icache_responder.sv
// Behavioural instruction memory answering icache requests after a fixed
// pipeline latency, with credit-based flow control into a response FIFO.
module vx_icache_responder
  import vx_icache_responder_pkg::*;
#(
  parameter int CORE_ID   = 0,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_WIDTH = NW_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [WORD_ADDR_W-1:0]       req_addr,
  input  logic [TAG_WIDTH-1:0]         req_tag,
  output logic                         req_ready,
  output logic                         rsp_valid,
  output logic [INSTR_W-1:0]           rsp_data,
  output logic [TAG_WIDTH-1:0]         rsp_tag,
  input  logic                         rsp_ready,
  input  logic                         init_valid,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
  input  logic [INSTR_W-1:0]           init_data,
  output logic                         oob_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int DATAW = INSTR_W + TAG_WIDTH;
  localparam int CRD_W = $clog2(RSP_DEPTH + 1);

  if (LATENCY < 1 || LATENCY > 4 || RSP_DEPTH < 2 || CORE_ID < 0) begin : g_bad_param
    $error("vx_icache_responder: unsupported parameter combination");
  end

  logic [INSTR_W-1:0] mem [MEM_WORDS];
  logic               req_fire;
  logic               rsp_fire;
  logic               in_range;
  logic [INSTR_W-1:0] rd_word;
  logic [CRD_W-1:0]   credits;
  logic [LATENCY-1:0] vld_p;
  logic [DATAW-1:0]   dat_p [LATENCY];

  assign req_ready = (credits < CRD_W'(RSP_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign in_range  = addr_in_range(req_addr, MEM_WORDS);
  assign rd_word   = in_range ? mem[req_addr[IDX_W-1:0]] : '0;

  // Program-load port; the request read above sees the pre-edge word.
  always_ff @(posedge clk) begin
    if (init_valid) mem[init_addr] <= init_data;
  end

  // ---- stage p0 captures read word and tag at accept; later stages shift ----
  // Data pipeline, not reset: validity is tracked separately in vld_p.
  always_ff @(posedge clk) begin
    if (req_fire) dat_p[0] <= {rd_word, req_tag};
    for (int i = 1; i < LATENCY; i++) dat_p[i] <= dat_p[i-1];
  end

  // Valid pipeline alongside the data stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= req_fire;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Credits count in-flight plus queued responses so the FIFO cannot overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   credits <= credits + CRD_W'(1);
        2'b01:   credits <= credits - CRD_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Sticky flag for any accepted request beyond the memory size.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     oob_err <= 1'b0;
    else if (req_fire && !in_range) oob_err <= 1'b1;
  end

  // ---- last pipeline stage writes the response FIFO ----
  vx_icache_rsp_fifo #(
    .DATAW (DATAW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p[LATENCY-1]),
    .push_data (dat_p[LATENCY-1]),
    .pop       (rsp_ready),
    .out_valid (rsp_valid),
    .out_data  ({rsp_data, rsp_tag})
  );

endmodule

// File: doc/vx_icache_responder.md
VX_ICACHE_RESPONDER -- requirements
Module: VX_icache_responder

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core index for debug prints only.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, instruction words held; power of two.
REQ-003 SHALL have parameter LATENCY, default 2, request-accept to FIFO-write cycles; range 1..4.
REQ-004 SHALL have parameter RSP_DEPTH, default 4, response FIFO entries and credit limit; power of two, at least 2.
REQ-005 SHALL have parameter TAG_WIDTH, default `NW_BITS, request/response tag width.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port req_valid, input, 1, icache core request valid.
REQ-009 SHALL have port req_addr, input, 30, word address (PC[31:2]).
REQ-010 SHALL have port req_tag, input, TAG_WIDTH, request tag (warp id).
REQ-011 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-012 SHALL have port rsp_valid, output, 1, response valid.
REQ-013 SHALL have port rsp_data, output, 32, instruction word.
REQ-014 SHALL have port rsp_tag, output, TAG_WIDTH, tag echoed from the request.
REQ-015 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-016 SHALL have ports init_valid (input, 1), init_addr (input, log2(MEM_WORDS)) and init_data (input, 32), forming the program-load write port.
REQ-017 SHALL have port oob_err, output, 1, sticky out-of-range address flag.

Function
REQ-018 A request SHALL fire when req_valid && req_ready; a response SHALL fire when rsp_valid && rsp_ready.
REQ-019 On fire, the block SHALL read mem[req_addr[log2(MEM_WORDS)-1:0]]; if req_addr >= MEM_WORDS, data SHALL be 32'h0 and oob_err SHALL set the next cycle.
REQ-020 Read data and tag SHALL traverse a LATENCY-stage valid/tag/data pipeline and be written to the response FIFO at edge k+LATENCY, where k is the accept edge.
REQ-021 The FIFO SHALL be first-word fall-through: with the FIFO empty, rsp_valid SHALL rise in the cycle after edge k+LATENCY.
REQ-022 Responses SHALL return in request order; rsp_data and rsp_tag SHALL stay stable while rsp_valid && !rsp_ready.
REQ-023 The credit counter, holding in-flight plus queued responses, SHALL increment on request fire and decrement on response fire; simultaneous fires SHALL leave it unchanged.
REQ-024 req_ready SHALL equal (credit counter < RSP_DEPTH), combinationally from registered state only; the FIFO SHALL never overflow.
REQ-025 init_valid SHALL write init_data to mem[init_addr] at the edge; a same-cycle request to that address SHALL return the old word (read-before-write).
REQ-026 Back-to-back requests SHALL sustain one per cycle while credits remain and rsp_ready is high.
REQ-027 oob_err SHALL remain set until reset.

Reset
REQ-028 Asserting reset SHALL asynchronously clear pipeline valids, FIFO pointers, credit counter and oob_err; rsp_valid=0, req_ready=1 after release.
REQ-029 Reset mid-operation SHALL drop all in-flight and queued responses; memory contents SHALL NOT be reset.

Structure
REQ-030 TAG_WIDTH default and the 30-bit word-address width SHALL live in the shared VX package/define header.
REQ-031 The response FIFO SHALL be the sub-module VX_icache_rsp_fifo (DATAW=32+TAG_WIDTH, DEPTH=RSP_DEPTH); the memory array and pipeline SHALL stay in the top.

Verification
REQ-032 Preload mem[5]=32'hDEADBEEF, request addr=5 tag=3, rsp_ready=1 -> rsp_valid in the cycle after edge k+2, data=DEADBEEF, tag=3.
REQ-033 Hold rsp_ready=0 and issue 6 requests -> exactly 4 accepted, then req_ready=0; raising rsp_ready drains 4 in order and req_ready returns to 1.
REQ-034 Issue 8 back-to-back requests, addrs 0..7, rsp_ready=1 -> 8 consecutive responses with matching tags, no bubbles.
REQ-035 Request addr=30'h400 (MEM_WORDS=1024) -> rsp_data=0, oob_err=1 and sticky thereafter.
REQ-036 Same-cycle init write of 32'h1 and request to addr 9 holding 32'h2 -> response 32'h2; next request -> 32'h1.
REQ-037 Assert reset with 3 responses outstanding -> no responses after release, credit counter=0, req_ready=1, memory retains preloaded words.
